// File: rtl/run_feeder_pkg.sv
// Shared types and constants for the run feeder: FSM states and key field layout.
package run_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTerm,
    StDone
  } state_e;

  localparam int unsigned KEY_LSB = 0;
  localparam int unsigned KEY_W   = 32;
  localparam logic [KEY_W-1:0] TERM_KEY = '0;

endpackage

// File: rtl/run_feeder_obuf.sv
// Two-entry first-word-fall-through buffer; dout reads 0 while empty.
module run_feeder_obuf #(
  parameter int unsigned WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_eff, push_eff;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    pop_eff  = pop & (cnt_q != 2'd0);
    // A push into a full buffer is only accepted alongside a pop.
    push_eff = push & ((cnt_q != 2'd2) | pop_eff);
    unique case ({push_eff, pop_eff})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din;
        else               tail_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        tail_d = '0;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);
  assign count = cnt_q;
  assign dout  = empty ? '0 : head_q;

endmodule

// File: rtl/run_feeder.sv
// Slices an FWFT source into runs of run_len beats, each followed by an all-zero terminator.
// Optional key-order checker enabled by defining RUN_FEEDER_ORDER_CHECK_EN.
module run_feeder
  import run_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_valid,
  input  logic [LEN_W-1:0]      i_run_len,
  input  logic [LEN_W-1:0]      i_num_runs,
  input  logic [DATA_WIDTH-1:0] i_src_data,
  input  logic                  i_src_empty,
  output logic                  o_src_read,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  input  logic                  i_read,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_order_err
);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      run_len_q, run_len_d, num_runs_q, num_runs_d;
  logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d, run_cnt_q, run_cnt_d;
  logic                  push, can_push, start;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  buf_full;
  logic [1:0]            buf_count;

  assign can_push = ~buf_full | i_read;
  assign o_done   = (state_q == StDone) & (buf_count == 2'd0);
  assign o_busy   = (state_q != StIdle);
  // A finished feeder accepts a new start exactly like an idle one.
  assign start    = i_cfg_valid & ((state_q == StIdle) | o_done);

  always_comb begin
    state_d    = state_q;
    run_len_d  = run_len_q;
    num_runs_d = num_runs_q;
    beat_cnt_d = beat_cnt_q;
    run_cnt_d  = run_cnt_q;
    o_src_read = 1'b0;
    push       = 1'b0;
    push_data  = i_src_data;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          run_len_d  = i_run_len;
          num_runs_d = i_num_runs;
          beat_cnt_d = '0;
          run_cnt_d  = '0;
          if (i_num_runs == '0)     state_d = StDone;
          else if (i_run_len == '0) state_d = StTerm;
          else                      state_d = StData;
        end
      end
      StData: begin
        if (~i_src_empty & can_push) begin
          o_src_read = 1'b1;
          push       = 1'b1;
          if (beat_cnt_q == run_len_q - LEN_W'(1)) begin
            beat_cnt_d = '0;
            state_d    = StTerm;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      StTerm: begin
        if (can_push) begin
          push      = 1'b1;
          push_data = DATA_WIDTH'(TERM_KEY);
          run_cnt_d = run_cnt_q + LEN_W'(1);
          if (run_cnt_q == num_runs_q - LEN_W'(1)) state_d = StDone;
          else if (run_len_q == '0)                state_d = StTerm;
          else                                     state_d = StData;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      run_len_q  <= '0;
      num_runs_q <= '0;
      beat_cnt_q <= '0;
      run_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_len_q  <= run_len_d;
      num_runs_q <= num_runs_d;
      beat_cnt_q <= beat_cnt_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  run_feeder_obuf #(
    .WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (i_read),
    .din   (push_data),
    .dout  (o_data),
    .full  (buf_full),
    .empty (o_empty),
    .count (buf_count)
  );

`ifdef RUN_FEEDER_ORDER_CHECK_EN
  logic [KEY_W-1:0] prev_key_q, push_key;
  logic             err_q;

  assign push_key = i_src_data[KEY_LSB +: KEY_W];

  // Keys must be non-zero and non-decreasing within a run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_key_q <= '0;
      err_q      <= 1'b0;
    end else if (push && state_q == StData) begin
      if (push_key == TERM_KEY || push_key < prev_key_q) err_q <= 1'b1;
      prev_key_q <= push_key;
    end else if (push && state_q == StTerm) begin
      prev_key_q <= '0;
    end
  end

  assign o_order_err = err_q;
`else
  assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_run_feeder.sv
// Self-checking bench for run_feeder: directed corner sequences plus a randomized job table.
module tb_run_feeder;

  localparam int DW = 512;
  localparam int LW = 16;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
  localparam bit OrderChk = 1'b1;
`else
  localparam bit OrderChk = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, cfg_valid, src_empty, src_read, o_empty, rd, busy, done, order_err;
  logic [LW-1:0] run_len, num_runs;
  logic [DW-1:0] src_data, o_data;

  always #5 clk = ~clk;

  run_feeder #(
    .DATA_WIDTH (DW),
    .LEN_W      (LW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_valid (cfg_valid),
    .i_run_len   (run_len),
    .i_num_runs  (num_runs),
    .i_src_data  (src_data),
    .i_src_empty (src_empty),
    .o_src_read  (src_read),
    .o_data      (o_data),
    .o_empty     (o_empty),
    .i_read      (rd),
    .o_busy      (busy),
    .o_done      (done),
    .o_order_err (order_err)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_q[$];
  bit            gap, rd_en, model_err;
  int            reads, n_src;
  logic [31:0]   prev_key;
  logic          s_read, s_empty, s_busy, s_done, s_err;
  logic [DW-1:0] s_data;

  typedef struct {
    int len;
    int runs;
    int src_prob;
    int rd_prob;
    int exp_total;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample just after, account pops at the posedge.
  task automatic cycle();
    src_empty = gap || (src_q.size() == 0);
    src_data  = (src_q.size() != 0) ? src_q[0] : '0;
    rd        = rd_en;
    #1;
    s_read  = src_read;
    s_empty = o_empty;
    s_data  = o_data;
    s_busy  = busy;
    s_done  = done;
    s_err   = order_err;
    @(posedge clk);
    if (s_read === 1'b1) begin
      if (src_q.size() != 0) void'(src_q.pop_front());
      reads++;
    end
    if (rd && s_empty === 1'b0) out_q.push_back(s_data);
    @(negedge clk);
  endtask

  task automatic clear_job();
    src_q.delete();
    exp_q.delete();
    out_q.delete();
    reads    = 0;
    n_src    = 0;
    prev_key = '0;
  endtask

  task automatic add_beat(input logic [31:0] key);
    logic [DW-1:0] beat;
    beat = '0;
    for (int w = 1; w < DW / 32; w++) beat[w*32 +: 32] = $urandom;
    beat[31:0] = key;
    src_q.push_back(beat);
    exp_q.push_back(beat);
    n_src++;
    if (OrderChk && (key == 0 || key < prev_key)) model_err = 1'b1;
    prev_key = key;
  endtask

  task automatic add_term();
    exp_q.push_back('0);
    prev_key = '0;
  endtask

  task automatic start(input int len, input int runs);
    run_len   = LW'(len);
    num_runs  = LW'(runs);
    cfg_valid = 1'b1;
    gap       = 1'b0;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    gap   = 1'b0;
    rd_en = 1'b0;
    cycle();
    rst       = 1'b0;
    model_err = 1'b0;
  endtask

  task automatic drain(input string name, input int src_prob, input int rd_prob);
    for (int c = 0; c < 5000; c++) begin
      gap   = ($urandom_range(0, 99) >= src_prob);
      rd_en = ($urandom_range(0, 99) < rd_prob);
      cycle();
      if (s_done === 1'b1) break;
    end
    check({name, "_done"}, DW'(s_done), DW'(1));
    check({name, "_count"}, DW'(out_q.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), out_q[i], exp_q[i]);
    check({name, "_reads"}, DW'(reads), DW'(n_src));
    check({name, "_err"}, DW'(s_err), DW'(model_err));
  endtask

  task automatic gen_random(input int len, input int runs);
    for (int r = 0; r < runs; r++) begin
      for (int b = 0; b < len; b++) add_beat(32'($urandom_range(1, 1000)));
      add_term();
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{len: 3, runs: 2, src_prob: 100, rd_prob: 100, exp_total: 8};
    vecs[1] = '{len: 0, runs: 3, src_prob: 100, rd_prob: 100, exp_total: 3};
    vecs[2] = '{len: 1, runs: 5, src_prob: 70,  rd_prob: 60,  exp_total: 10};
    vecs[3] = '{len: 5, runs: 3, src_prob: 50,  rd_prob: 80,  exp_total: 18};
    vecs[4] = '{len: 2, runs: 4, src_prob: 90,  rd_prob: 30,  exp_total: 12};
    vecs[5] = '{len: 7, runs: 2, src_prob: 40,  rd_prob: 40,  exp_total: 16};
    vecs[6] = '{len: 4, runs: 0, src_prob: 100, rd_prob: 100, exp_total: 0};
    vecs[7] = '{len: 1, runs: 1, src_prob: 100, rd_prob: 100, exp_total: 2};

    cfg_valid = 1'b0;
    run_len   = '0;
    num_runs  = '0;
    model_err = 1'b0;
    clear_job();
    @(negedge clk);

    // Reset state, with a non-empty source present.
    add_beat(32'd99);
    rst = 1'b1;
    gap = 1'b0;
    rd_en = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    model_err = 1'b0;
    cycle();
    check("rst_empty", DW'(s_empty), DW'(1));
    check("rst_data", s_data, '0);
    check("rst_src_read", DW'(s_read), DW'(0));
    check("rst_busy", DW'(s_busy), DW'(0));
    check("rst_done", DW'(s_done), DW'(0));
    check("rst_err", DW'(s_err), DW'(0));

    // Back-to-back runs at full throughput.
    clear_job();
    add_beat(32'd5); add_beat(32'd7); add_beat(32'd9); add_term();
    add_beat(32'd2); add_beat(32'd4); add_beat(32'd6); add_term();
    rd_en = 1'b1;
    start(3, 2);
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (c == 1) check("t1_first_empty", DW'(s_empty), DW'(1));
      if (c >= 2 && c <= 9) check($sformatf("t1_cyc%0d", c), s_data, exp_q[c-2]);
      if (c == 9) check("t1_not_done_yet", DW'(s_done), DW'(0));
      if (c == 10) check("t1_done", DW'(s_done), DW'(1));
    end

    // Zero-length runs: terminators only.
    clear_job();
    add_term(); add_term(); add_term();
    start(0, 3);
    drain("t2", 100, 100);

    // Backpressure: buffer fills after two pops, then drains intact.
    clear_job();
    add_beat(32'd10); add_beat(32'd20); add_beat(32'd30); add_beat(32'd40); add_term();
    rd_en = 1'b0;
    start(4, 1);
    for (int c = 0; c < 5; c++) cycle();
    check("t3_reads_held", DW'(reads), DW'(2));
    check("t3_not_empty", DW'(s_empty), DW'(0));
    check("t3_head", s_data, exp_q[0]);
    drain("t3", 100, 100);

    // Source stall mid-run: no early terminator.
    clear_job();
    add_beat(32'd11); add_beat(32'd12); add_beat(32'd13); add_beat(32'd14); add_term();
    rd_en = 1'b1;
    start(4, 1);
    for (int c = 0; c < 10 && reads < 2; c++) cycle();
    gap = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    check("t4_out_during_gap", DW'(out_q.size()), DW'(2));
    check("t4_empty_during_gap", DW'(s_empty), DW'(1));
    drain("t4", 100, 100);

    // Reset mid-run with a full buffer.
    clear_job();
    add_beat(32'd1); add_beat(32'd2); add_beat(32'd3); add_beat(32'd4); add_term();
    rd_en = 1'b0;
    start(4, 1);
    for (int c = 0; c < 3; c++) cycle();
    check("t5_full_reads", DW'(reads), DW'(2));
    do_reset();
    cycle();
    check("t5_empty", DW'(s_empty), DW'(1));
    check("t5_busy", DW'(s_busy), DW'(0));
    check("t5_done", DW'(s_done), DW'(0));
    check("t5_data", s_data, '0);
    clear_job();
    add_beat(32'd77); add_term();
    rd_en = 1'b1;
    start(1, 1);
    drain("t5", 100, 100);

    // Key order violations.
    do_reset();
    clear_job();
    add_beat(32'd8); add_beat(32'd3); add_term();
    rd_en = 1'b1;
    start(2, 1);
    for (int c = 0; c < 10 && reads < 2; c++) cycle();
    cycle();
    check("t6_err_after_push", DW'(s_err), DW'(OrderChk));
    drain("t6", 100, 100);
    clear_job();
    gen_random(2, 2);
    start(2, 2);
    drain("t6_sticky", 80, 80);
    do_reset();
    cycle();
    check("t6_err_cleared", DW'(s_err), DW'(0));
    clear_job();
    add_beat(32'd5); add_beat(32'd0); add_beat(32'd6); add_term();
    start(3, 1);
    drain("t7_zero_key", 100, 100);

    // Randomized job table.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      clear_job();
      gen_random(vecs[v].len, vecs[v].runs);
      start(vecs[v].len, vecs[v].runs);
      drain($sformatf("rnd%0d", v), vecs[v].src_prob, vecs[v].rd_prob);
      check($sformatf("rnd%0d_total", v), DW'(out_q.size()), DW'(vecs[v].exp_total));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
